// File: rtl/serial_subtractor16.sv
// rtl/serial_subtractor16.sv - digit-serial subtractor D = A - B - Bin, CHUNK bits per clock
// start/busy/done handshake; results change only on completion of an operation.
module serial_subtractor16 #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / ((CHUNK < 1) ? 1 : CHUNK);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("serial_subtractor16: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, res;
  logic               a_msb, b_msb, brw;
  logic [CW-1:0]      cnt;
  logic [CHUNK:0]     chunk_diff;
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic [WIDTH-1:0]   res_nxt;
  logic               last;

  // Bit CHUNK of the widened difference is the chunk borrow-out.
  assign chunk_diff = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]} - {{CHUNK{1'b0}}, brw};
  assign res_cat    = {chunk_diff[CHUNK-1:0], res};
  assign res_nxt    = res_cat[WIDTH+CHUNK-1:CHUNK];
  assign last       = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      brw   <= 1'b0;
      cnt   <= '0;
      D     <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            brw   <= Bin;
            res   <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> CHUNK;
          b_sh <= b_sh >> CHUNK;
          res  <= res_nxt;
          brw  <= chunk_diff[CHUNK];
          cnt  <= cnt + CW'(1);
          // Publish on the final chunk so D/Bout/V never expose partial results.
          if (last) begin
            D    <= res_nxt;
            Bout <= chunk_diff[CHUNK];
            V    <= (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// tb/tb_serial_subtractor16.sv - directed checks of serial_subtractor16 across CHUNK = 4, 1, 2, 8, 16
module tb_serial_subtractor16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        Bin = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic [15:0] d_w    [5];
  logic        bout_w [5];
  logic        v_w    [5];
  logic        busy_w [5];
  logic        done_w [5];

  int checks = 0;
  int errors = 0;
  int chs [5] = '{4, 1, 2, 8, 16};

  always #5 clk = ~clk;

  // Instance 0 is the default CHUNK=4 build; the rest form the parameter sweep.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    serial_subtractor16 #(
      .WIDTH(16),
      .CHUNK(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 2 : g == 3 ? 8 : 16)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
      .D(d_w[g]), .Bout(bout_w[g]), .V(v_w[g]), .busy(busy_w[g]), .done(done_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input logic [15:0] ed, input logic eb, input logic ev, input logic chk_v);
    int cyc;
    int busy_n;
    @(negedge clk);
    A = a; B = b; Bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_n = 0;
    while (!done_w[0] && cyc < 20) begin
      if (busy_w[0]) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_busy_cycles"}, busy_n, 4);
    check({tag, "_d"}, d_w[0], ed);
    check({tag, "_bout"}, bout_w[0], eb);
    if (chk_v) check({tag, "_v"}, v_w[0], ev);
    check({tag, "_busy_in_done"}, busy_w[0], 0);
    @(negedge clk);
    check({tag, "_done_pulse_len"}, done_w[0], 0);
  endtask

  initial begin
    logic [15:0] ha [24];
    logic [15:0] hb [24];
    logic        hbi [24];
    logic [15:0] d_seen;
    logic [16:0] r;
    logic [15:0] a, b, s;
    logic        bi, cout;
    int          dones;
    int          lat [5];
    logic [15:0] dc [5];
    logic        bc [5];

    #12;
    check("reset_d", d_w[0], 0);
    check("reset_bout", bout_w[0], 0);
    check("reset_v", v_w[0], 0);
    check("reset_busy", busy_w[0], 0);
    check("reset_done", done_w[0], 0);
    @(negedge clk);
    rst = 1'b1;

    run_op("nominal", 16'hF04E, 16'hBCA9, 1'b0, 16'h33A5, 1'b0, 1'b0, 1'b1);
    run_op("wrap1", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    run_op("wrap_bin", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b1);
    run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b1);
    run_op("equal", 16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_op("zero_minus_max", 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // start pulsed mid-RUN with other operands must be ignored
    @(negedge clk);
    A = 16'h1234; B = 16'h0234; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    d_seen = '0;
    for (int k = 0; k < 12; k++) begin
      if (done_w[0]) begin
        dones++;
        d_seen = d_w[0];
      end
      @(negedge clk);
    end
    check("ignore_start_dones", dones, 1);
    check("ignore_start_d", d_seen, 16'h1000);

    // start held high: accepts at k = 0, 6, 12, 18; done at k = 5, 11, 17, 23
    repeat (20) @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      if (k < 20) begin
        ha[k] = 16'($urandom); hb[k] = 16'($urandom); hbi[k] = 1'($urandom);
        A = ha[k]; B = hb[k]; Bin = hbi[k]; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k >= 1) begin
        check($sformatf("hold_done_k%0d", k), done_w[0], (k % 6) == 5);
        if ((k % 6) == 5) begin
          r = {1'b0, ha[k-5]} - {1'b0, hb[k-5]} - {16'd0, hbi[k-5]};
          check($sformatf("hold_d_k%0d", k), d_w[0], r[15:0]);
          check($sformatf("hold_bout_k%0d", k), bout_w[0], r[16]);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;

    // reset pulse during the 2nd RUN cycle aborts the operation
    run_op("pre_reset", 16'hF04E, 16'hBCA9, 1'b0, 16'h33A5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", busy_w[0], 0);
    check("abort_d", d_w[0], 0);
    check("abort_bout", bout_w[0], 0);
    check("abort_v", v_w[0], 0);
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done_w[0]) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_d_held", d_w[0], 0);
    run_op("after_reset", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1);

    // ripple-adder round trip: (a + b) - b returns a, borrow equals carry
    for (int i = 0; i < 20; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      {cout, s} = {1'b0, a} + {1'b0, b};
      run_op($sformatf("xadd%0d", i), s, b, 1'b0, a, cout, 1'b0, 1'b0);
    end

    // all CHUNK builds against the reference difference
    repeat (20) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      bi = 1'($urandom);
      if (i == 0) begin a = 16'h0000; b = 16'hFFFF; bi = 1'b1; end
      if (i == 1) begin a = 16'hABCD; b = 16'hABCD; bi = 1'b0; end
      r = {1'b0, a} - {1'b0, b} - {16'd0, bi};
      @(negedge clk);
      A = a; B = b; Bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int g = 0; g < 5; g++) begin
        lat[g] = 0; dc[g] = '0; bc[g] = 1'b0;
      end
      for (int c = 1; c <= 20; c++) begin
        for (int g = 0; g < 5; g++) begin
          if (done_w[g] && lat[g] == 0) begin
            lat[g] = c; dc[g] = d_w[g]; bc[g] = bout_w[g];
          end
        end
        @(negedge clk);
      end
      for (int g = 0; g < 5; g++) begin
        check($sformatf("sweep%0d_c%0d_lat", i, chs[g]), lat[g], 16 / chs[g] + 1);
        check($sformatf("sweep%0d_c%0d_d", i, chs[g]), dc[g], r[15:0]);
        check($sformatf("sweep%0d_c%0d_bout", i, chs[g]), bc[g], r[16]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor16.md
Name: serial_subtractor16

Overview:
- Multi-cycle, digit-serial subtractor: computes D = A - B - Bin over WIDTH/CHUNK clock cycles using a registered borrow chain.
- Inverse-direction companion to the combinational 16-bit adders (ripple, carry-select). It serves area-constrained datapaths and is a sequential cross-check target for those adders: A + B computed combinationally, then D - B computed serially, must return A.
- Uses a start/busy/done handshake so a controller FSM can sequence it.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits subtracted per cycle. CHUNK must divide WIDTH, and 1 <= CHUNK <= WIDTH; other values are illegal, and the implementation flags them with an elaboration-time error.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- Bin  input  1  borrow-in; captured on the accepting edge.
- D  output  WIDTH  difference, registered.
- Bout  output  1  borrow-out: 1 iff A < B + Bin (unsigned).
- V  output  1  two's-complement overflow of A - B - Bin.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; D/Bout/V are valid while high.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; D=0; Bout=0; V=0; busy=0; done=0; internal shift registers and chunk counter cleared. Reset asserted mid-RUN aborts the operation: no done pulse and no D update. After release, the block is in IDLE.
- States:
  - IDLE: start=1 at an edge captures A, B, Bin into working registers, loads borrow register with Bin, sets count=0, goes to RUN. busy goes high after that edge.
  - RUN: each edge subtracts the low CHUNK bits of the A and B working registers with the current borrow. Shifts the CHUNK result bits into the result register from the MSB side, shifts the operand registers right by CHUNK, stores the chunk borrow-out, increments count. On the edge processing chunk N-1 (N = WIDTH/CHUNK), goes to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Output timing (DONE):
  - Entering DONE loads D from the result register and Bout from the final borrow.
  - The same edge sets V = A[MSB]^B[MSB] & A[MSB]^D[MSB], using captured A/B.
  - done=1 and busy=0 throughout DONE.
- Latency: start accepted at edge E0; RUN edges E1..EN; done high in the cycle after EN. Default (N=4): done high in the 5th cycle after the start edge. CHUNK=WIDTH gives N=1.
- D, Bout and V hold their value from the last completed operation until the next completion or reset. They never show partial results.
- Handshake:
  - start is ignored in RUN and DONE; it is not queued.
  - start held high continuously begins a new operation on the first IDLE edge. Back-to-back throughput is therefore one result per N+2 cycles.
  - Changes to A, B or Bin after the accepting edge have no effect on the running operation.
- Arithmetic: exact modulo 2^WIDTH. {Bout, D} equals the (WIDTH+1)-bit value 2^WIDTH + A - B - Bin, with Bout inverted from the carry. Boundary cases:
  - A=B with Bin=0 gives D=0, Bout=0.
  - A=0, B=2^WIDTH-1, Bin=1 gives D=0, Bout=1.

Test Plan:
- Nominal: A=16'hF04E, B=16'hBCA9, Bin=0, start pulse -> done pulse in the 5th cycle after the start edge; D=16'h33A5, Bout=0, V=0; busy high for exactly 4 cycles.
- Borrow and wrap: A=16'h0000, B=16'h0001, Bin=0 -> D=16'hFFFF, Bout=1, V=0. Then A=0, B=0, Bin=1 -> D=16'hFFFF, Bout=1, V=0.
- Signed overflow: A=16'h8000, B=16'h0001, Bin=0 -> D=16'h7FFF, Bout=0, V=1. Then A=16'h7FFF, B=16'hFFFF, Bin=0 -> D=16'h8000, Bout=1, V=1.
- Handshake:
  - Pulse start again during RUN with different A/B -> ignored; first result unchanged, and exactly one done pulse.
  - Hold start high for 20 cycles -> done every 6 cycles; results match the operands present at each accepting edge.
- Reset mid-operation: drop rst for 1 ns during the 2nd RUN cycle -> busy=0, D=0, Bout=0, V=0 immediately; no done pulse follows. A fresh start completes normally.
- Parameter sweep and adder cross-check:
  - Re-elaborate with CHUNK=1, 2, 8 and 16; run 1000 random {A, B, Bin}.
  - D/Bout must match the reference A-B-Bin, with latency N+1 cycles to done.
  - Cross-check against the 16-bit ripple adder: A + B (Cin=0) produces sum S and carry Cout. Feed D-operand A=S, B=B, Bin=0 into this block; the result must give D=A and Bout=Cout.
